// File: rtl/rll_key_pkg.sv
// Shared types and constants for the rll key loader.
// Optional build macro: RLL_KEY_SCRUB_EN (see rll_key_loader.sv).
package rll_key_pkg;

   localparam int unsigned KEY_W_DEF     = 32;
   localparam int unsigned MAX_FAILS_DEF = 3;
   localparam int unsigned FAIL_W_DEF    = 4;

   // A correct key plus its parity bit always has even parity.
   localparam logic PARITY_EVEN = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      CHECK  = 2'd2,
      LOCKED = 2'd3
   } state_e;

   // Reduction parity of a key-wide vector.
   function automatic logic red_parity(input logic [KEY_W_DEF-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/rll_key_loader_if.sv
// Serial key stream and load-control handshake between programmer and loader.
interface rll_key_loader_if;

   logic load_start;
   logic abort;
   logic key_bit;
   logic key_bit_valid;
   logic key_bit_ready;

   modport master (
      output load_start, abort, key_bit, key_bit_valid,
      input  key_bit_ready
   );

   modport slave (
      input  load_start, abort, key_bit, key_bit_valid,
      output key_bit_ready
   );

endinterface

// File: rtl/rll_key_shifter.sv
// Serial-to-parallel key capture: bit counter, shadow register, parity bit.
module rll_key_shifter #(
   parameter int unsigned KEY_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             key_bit,
   output logic [KEY_W-1:0] shadow,
   output logic             parity,
   output logic             last_bit
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] shadow_q, shadow_d;
   logic             parity_q, parity_d;
   logic             last_q, last_d;

   // Next-state: clear, store key bit at cnt, or capture the trailing parity bit.
   always_comb begin
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      parity_d = parity_q;
      last_d   = last_q;
      if (clear) begin
         cnt_d    = '0;
         shadow_d = '0;
         parity_d = 1'b0;
         last_d   = 1'b0;
      end else if (shift_en) begin
         if (last_q) begin
            parity_d = key_bit;
            last_d   = 1'b0;
         end else begin
            for (int i = 0; i < int'(KEY_W); i++) begin
               if (cnt_q == CNT_W'(i)) shadow_d[i] = key_bit;
            end
            cnt_d  = cnt_q + CNT_W'(1);
            last_d = (cnt_d == CNT_W'(KEY_W));
         end
      end
   end

   // Capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         parity_q <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         parity_q <= parity_d;
         last_q   <= last_d;
      end
   end

   assign shadow   = shadow_q;
   assign parity   = parity_q;
   assign last_bit = last_q;

endmodule

// File: rtl/rll_key_loader.sv
// Loads the rll logic-locking key serially, parity-checks it, commits it to
// the core, and locks out after repeated failures.
// Optional build macro: RLL_KEY_SCRUB_EN -- clear key_out whenever key_valid drops.
module rll_key_loader
   import rll_key_pkg::*;
#(
   parameter int unsigned KEY_W     = KEY_W_DEF,
   parameter int unsigned MAX_FAILS = MAX_FAILS_DEF,
   parameter int unsigned FAIL_W    = FAIL_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   rll_key_loader_if.slave   bus,
   output logic [KEY_W-1:0]  key_out,
   output logic              key_valid,
   output logic              busy,
   output logic              load_done,
   output logic              load_err,
   output logic              lockout,
   output logic [FAIL_W-1:0] fail_cnt
);

   state_e            state_q, state_d;
   logic [KEY_W-1:0]  shadow;
   logic              parity;
   logic              last_bit;

   logic              shift_en_c, clear_c, parity_ok_c;
   logic [FAIL_W-1:0] fail_inc_c;

   logic [KEY_W-1:0]  key_out_q, key_out_d;
   logic              key_valid_q, key_valid_d;
   logic              busy_q, busy_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic              lockout_q, lockout_d;
   logic              key_bit_ready_q, key_bit_ready_d;
   logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;

   // Abort beats a simultaneous bit; a load start or abort restarts the shadow.
   always_comb begin
      shift_en_c  = (state_q == SHIFT) & bus.key_bit_valid & key_bit_ready_q & ~bus.abort;
      clear_c     = ((state_q == IDLE) & bus.load_start) | ((state_q == SHIFT) & bus.abort);
      parity_ok_c = ((red_parity(shadow) ^ parity) == PARITY_EVEN);
      fail_inc_c  = (fail_cnt_q == FAIL_W'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);
   end

   rll_key_shifter #(.KEY_W(KEY_W)) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_c),
      .shift_en (shift_en_c),
      .key_bit  (bus.key_bit),
      .shadow   (shadow),
      .parity   (parity),
      .last_bit (last_bit)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (bus.load_start) state_d = SHIFT;
         SHIFT: begin
            if (bus.abort)                   state_d = IDLE;
            else if (shift_en_c && last_bit) state_d = CHECK;
         end
         CHECK: begin
            if (parity_ok_c)                            state_d = IDLE;
            else if (fail_inc_c == FAIL_W'(MAX_FAILS)) state_d = LOCKED;
            else                                        state_d = IDLE;
         end
         LOCKED: state_d = LOCKED;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; status flags follow the next state.
   always_comb begin
      key_out_d       = key_out_q;
      key_valid_d     = key_valid_q;
      fail_cnt_d      = fail_cnt_q;
      load_done_d     = 1'b0;
      load_err_d      = 1'b0;
      key_bit_ready_d = (state_d == SHIFT);
      busy_d          = (state_d == SHIFT) || (state_d == CHECK);
      lockout_d       = (state_d == LOCKED);
      if (state_q == CHECK) begin
         if (parity_ok_c) begin
            key_out_d   = shadow;
            key_valid_d = 1'b1;
            fail_cnt_d  = '0;
            load_done_d = 1'b1;
         end else begin
            key_valid_d = 1'b0;
            fail_cnt_d  = fail_inc_c;
            load_err_d  = 1'b1;
`ifdef RLL_KEY_SCRUB_EN
            key_out_d   = '0;
`else
            key_out_d   = key_out_q;
`endif
         end
      end
      if (state_q == LOCKED) key_valid_d = 1'b0;
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_out_q       <= '0;
         key_valid_q     <= 1'b0;
         fail_cnt_q      <= '0;
         load_done_q     <= 1'b0;
         load_err_q      <= 1'b0;
         key_bit_ready_q <= 1'b0;
         busy_q          <= 1'b0;
         lockout_q       <= 1'b0;
      end else begin
         key_out_q       <= key_out_d;
         key_valid_q     <= key_valid_d;
         fail_cnt_q      <= fail_cnt_d;
         load_done_q     <= load_done_d;
         load_err_q      <= load_err_d;
         key_bit_ready_q <= key_bit_ready_d;
         busy_q          <= busy_d;
         lockout_q       <= lockout_d;
      end
   end

   assign key_out           = key_out_q;
   assign key_valid         = key_valid_q;
   assign fail_cnt          = fail_cnt_q;
   assign load_done         = load_done_q;
   assign load_err          = load_err_q;
   assign busy              = busy_q;
   assign lockout           = lockout_q;
   assign bus.key_bit_ready = key_bit_ready_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader with hand-computed expectations.
module tb_rll_key_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] key_out;
   logic        key_valid, busy, load_done, load_err, lockout;
   logic [3:0]  fail_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;

   rll_key_loader_if bus ();

   rll_key_loader dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .key_out   (key_out),
      .key_valid (key_valid),
      .busy      (busy),
      .load_done (load_done),
      .load_err  (load_err),
      .lockout   (lockout),
      .fail_cnt  (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
   endtask

   // Send the first nbits of {parity, key}, LSB first; stalls randomly when asked.
   task automatic send_bits(input logic [32:0] stream, input int nbits, input bit stall);
      int sent = 0;
      int cyc  = 0;
      while (sent < nbits && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (stall && $urandom_range(0, 1) == 0) begin
            bus.key_bit_valid = 1'b0;
         end else begin
            bus.key_bit_valid = 1'b1;
            bus.key_bit       = stream[sent];
            if (bus.key_bit_ready) sent++;
         end
      end
      chk("bit_handshake_count", 32'(sent), 32'(nbits));
      @(negedge clk);
      bus.key_bit_valid = 1'b0;
   endtask

   // Full load; returns in the cycle after the result edge.
   task automatic run_load(input string tag, input logic [31:0] key, input logic par,
                           input bit stall, input bit pass, input logic [31:0] exp_key,
                           input logic [3:0] exp_fail, input bit exp_lock);
      start_load();
      send_bits({par, key}, 33, stall);
      chk({tag, "_check_busy"}, 32'(busy), 32'(1));
      chk({tag, "_check_ready"}, 32'(bus.key_bit_ready), 32'(0));
      chk({tag, "_check_no_done"}, 32'(load_done), 32'(0));
      @(negedge clk);
      chk({tag, "_done"}, 32'(load_done), 32'(pass));
      chk({tag, "_err"}, 32'(load_err), 32'(!pass));
      chk({tag, "_key_valid"}, 32'(key_valid), 32'(pass));
      chk({tag, "_key_out"}, key_out, exp_key);
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(exp_fail));
      chk({tag, "_lockout"}, 32'(lockout), 32'(exp_lock));
      chk({tag, "_busy_after"}, 32'(busy), 32'(0));
      @(negedge clk);
      chk({tag, "_pulse_clear"}, 32'(load_done | load_err), 32'(0));
   endtask

   logic [31:0] fail_key;

   initial begin
      bus.load_start    = 1'b0;
      bus.abort         = 1'b0;
      bus.key_bit       = 1'b0;
      bus.key_bit_valid = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_key_out", key_out, 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'(0));
      chk("rst_ready", 32'(bus.key_bit_ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_pulses", 32'({load_done, load_err}), 32'(0));
      chk("rst_lockout", 32'(lockout), 32'(0));
      chk("rst_fail_cnt", 32'(fail_cnt), 32'(0));
      rst = 1'b0;

      // Good load, popcount 16, parity 0
      run_load("good_a5", 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 4'd0, 1'b0);

      // Bad parity: old key held unless scrubbing
`ifdef RLL_KEY_SCRUB_EN
      fail_key = 32'h0;
`else
      fail_key = 32'hA5A5_0F0F;
`endif
      run_load("bad_1", 32'h0000_0001, 1'b0, 1'b0, 1'b0, fail_key, 4'd1, 1'b0);

      // Recommit, then abort a load after 10 bits
      run_load("good_a5_again", 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 4'd0, 1'b0);
      start_load();
      chk("shift_key_valid_held", 32'(key_valid), 32'(1));
      send_bits({1'b0, 32'hFFFF_FFFF}, 10, 1'b0);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_ready", 32'(bus.key_bit_ready), 32'(0));
      chk("abort_key_out", key_out, 32'hA5A5_0F0F);
      chk("abort_key_valid", 32'(key_valid), 32'(1));
      chk("abort_no_pulse", 32'({load_done, load_err}), 32'(0));

      // Popcount 13, parity 1
      run_load("good_1234", 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 4'd0, 1'b0);

      // Popcount 24, parity 0, with random stalls
      run_load("stall_dead", 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'd0, 1'b0);

      // Three consecutive failures lead to lockout
`ifdef RLL_KEY_SCRUB_EN
      fail_key = 32'h0;
`else
      fail_key = 32'hDEAD_BEEF;
`endif
      run_load("lock_f1", 32'h0000_0001, 1'b0, 1'b0, 1'b0, fail_key, 4'd1, 1'b0);
      run_load("lock_f2", 32'h0000_0001, 1'b0, 1'b0, 1'b0, fail_key, 4'd2, 1'b0);
      run_load("lock_f3", 32'h0000_0001, 1'b0, 1'b0, 1'b0, fail_key, 4'd3, 1'b1);

      // Locked: load_start and abort ignored
      start_load();
      chk("locked_ready", 32'(bus.key_bit_ready), 32'(0));
      chk("locked_busy", 32'(busy), 32'(0));
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("locked_lockout", 32'(lockout), 32'(1));
      chk("locked_key_valid", 32'(key_valid), 32'(0));
      chk("locked_fail_cnt", 32'(fail_cnt), 32'(3));
      chk("locked_key_out", key_out, fail_key);

      // Reset exits lockout
      rst = 1'b1;
      #1;
      chk("unlock_lockout", 32'(lockout), 32'(0));
      chk("unlock_fail_cnt", 32'(fail_cnt), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // Async reset mid-shift after 17 bits
      run_load("pre_rst", 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 4'd0, 1'b0);
      start_load();
      send_bits({1'b1, 32'h1234_5678}, 17, 1'b0);
      chk("mid_busy_before_rst", 32'(busy), 32'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_key_out", key_out, 32'h0);
      chk("arst_key_valid", 32'(key_valid), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      chk("arst_ready", 32'(bus.key_bit_ready), 32'(0));
      chk("arst_lockout_fail", 32'({lockout, fail_cnt}), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      run_load("post_rst", 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Sequencer that loads the 32-bit logic-locking key for the rll benchmark netlists (keyIn_0_0..keyIn_0_31) from a serial bit stream.
- Checks a trailing parity bit, then commits the key to a parallel register that drives the locked circuit's key inputs.
- Counts failed load attempts and enters a sticky lockout after a limit.
- Sits between the test/programming interface and the locked combinational core.

Parameters:
- KEY_W, 32, key width; bit i drives keyIn_0_i.
- MAX_FAILS, 3, consecutive parity failures that trigger lockout (1..15).
- FAIL_W, 4, fail counter width; must satisfy 2^FAIL_W > MAX_FAILS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a key load (ignored unless IDLE).
- abort  in  1  cancels an in-progress load.
- key_bit  in  1  serial key data, LSB (bit 0) first, then 1 parity bit.
- key_bit_valid  in  1  key_bit is presented this cycle.
- key_bit_ready  out  1  loader accepts key_bit this cycle.
- key_out  out  KEY_W  committed key to the locked core.
- key_valid  out  1  key_out holds a parity-checked key.
- busy  out  1  high in SHIFT or CHECK.
- load_done  out  1  one-cycle pulse on successful commit.
- load_err  out  1  one-cycle pulse on parity failure.
- lockout  out  1  sticky; high in LOCKED.
- fail_cnt  out  FAIL_W  consecutive-failure count.

Behaviour:
- Reset values:
  - key_out = 0, key_valid = 0, key_bit_ready = 0, busy = 0.
  - load_done = 0, load_err = 0, lockout = 0, fail_cnt = 0.
  - State = IDLE; shift register = 0; bit counter = 0.
- States: IDLE, SHIFT, CHECK, LOCKED. The encoding is registered.
- IDLE
  - On load_start: go to SHIFT, clear the shift register and bit counter.
  - key_valid and key_out are unchanged.
- SHIFT
  - key_bit_ready = 1.
  - A bit is accepted when key_bit_valid & key_bit_ready.
  - Bits 0..KEY_W-1 go into shadow[cnt]. Bit KEY_W is the parity bit and is stored separately.
  - After the parity bit is accepted, go to CHECK the next cycle.
  - No timeout; stalls with key_bit_valid low are allowed indefinitely.
- CHECK (one cycle, key_bit_ready = 0)
  - Pass condition: XOR(shadow) ^ parity == 0 (even parity over KEY_W+1 bits).
  - Pass:
    - key_out <= shadow, key_valid <= 1, fail_cnt <= 0, load_done pulse.
    - Go to IDLE.
    - key_out changes only on this edge; latency from the parity-bit handshake to key_valid is 2 cycles.
  - Fail:
    - load_err pulse, fail_cnt <= fail_cnt+1, key_valid <= 0.
    - If fail_cnt+1 == MAX_FAILS, go to LOCKED; otherwise go to IDLE.
- LOCKED
  - lockout = 1, key_valid = 0, key_bit_ready = 0.
  - load_start and abort are ignored. Only rst exits.
- abort
  - In SHIFT: return to IDLE next cycle and discard the shadow. key_out, key_valid and fail_cnt are unchanged; no pulses.
  - In CHECK: abort is ignored and the check completes.
  - In IDLE or LOCKED: no effect.
- Simultaneous events:
  - load_start & abort in IDLE: load_start wins.
  - abort & an accepted bit in SHIFT: abort wins and the bit is dropped.
- A new load does not drop key_valid until CHECK; the previous key stays applied while shifting.
- fail_cnt saturates at MAX_FAILS and never wraps.
- rst asserted mid-load: immediate return to all reset values; the partial key is lost.

Optional Feature:
- Macro: RLL_KEY_SCRUB_EN.
- Defined:
  - key_out is forced to all-zero whenever key_valid = 0, including from the CHECK-fail edge and throughout LOCKED.
  - This applies as a registered clear on the same edge that drops key_valid.
- Not defined:
  - key_out holds the last committed key after a failure or lockout; only key_valid drops.

Decomposition:
- Package rll_key_pkg holds:
  - the state enum type (IDLE/SHIFT/CHECK/LOCKED);
  - localparam PARITY_EVEN = 1'b0;
  - a function computing the reduction parity of a KEY_W vector.
- One sub-module: rll_key_shifter.
  - Contains the bit counter, shadow register and parity capture.
  - Interface: clear, shift_en, key_bit → shadow, parity, last_bit.
- The FSM, fail counter and commit register stay in rll_key_loader.

Test Plan:
- Reset, then load key 32'hA5A5_0F0F with parity bit 0, no stalls → load_done 2 cycles after the parity handshake; key_out = 32'hA5A5_0F0F; key_valid = 1; fail_cnt = 0.
- Load 32'h0000_0001 with parity 0 (wrong) → load_err pulse; fail_cnt = 1; key_valid = 0. With RLL_KEY_SCRUB_EN, key_out = 0; without it, key_out holds the prior key.
- Three consecutive bad-parity loads (MAX_FAILS = 3) → lockout = 1 after the third CHECK. A further load_start produces no SHIFT and key_bit_ready stays 0. Asserting rst clears lockout and fail_cnt.
- Abort after 10 bits of key 32'hFFFF_FFFF → back in IDLE; the previous key_out/key_valid are unchanged; the next full load of 32'h1234_5678 with parity 1 commits correctly.
- Randomly deassert key_bit_valid on 50% of cycles while loading 32'hDEAD_BEEF, parity 0 → same commit result; no bit is double-counted or skipped.
- Assert rst asynchronously mid-SHIFT (bit 17) → all outputs at reset values before the next clk edge; the subsequent load succeeds.
